// File: rtl/uart_txr.sv
// uart_txr: 8N1 UART transmitter with a small byte FIFO in front.
// Bytes enter over a valid/ready handshake, are queued, and are shifted out LSB-first
// with CLKS_PER_BAUD_PERIOD clocks per bit, matching the companion receiver's timing.
// Line, busy and done are registered images of the state held during the previous
// cycle, so every output moves on the same edge and the line never glitches.
module uart_txr #(
   parameter int CLKS_PER_BAUD_PERIOD = 434,
   parameter int FIFO_DEPTH           = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_data_valid,
   input  logic [7:0] i_data_byte,
   output logic       o_data_ready,
   output logic       o_tx_data_line,
   output logic       o_tx_busy,
   output logic       o_tx_done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CLK_W = $clog2(CLKS_PER_BAUD_PERIOD);

   localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BAUD_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [2:0]       BIT_LAST = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      START_BIT,
      DATA_BITS,
      STOP_BIT,
      CLEANUP
   } state_t;

   state_t           state;
   logic [CLK_W-1:0] clk_ctr;
   logic [2:0]       bit_ctr;
   logic [7:0]       shift_reg;

   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;

   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;
   logic baud_last;

   // FIFO status comes only from the registered count, so a same-cycle pop never
   // opens a slot for that cycle's push and a fresh push is invisible to IDLE until
   // the following cycle.
   assign fifo_full    = (fifo_cnt == CNT_FULL);
   assign fifo_empty   = (fifo_cnt == '0);
   assign o_data_ready = !fifo_full && !i_rst;
   assign push         = i_data_valid && o_data_ready;
   assign pop          = (state == IDLE) && !fifo_empty && !i_rst;
   assign baud_last    = (clk_ctr == CLK_LAST);

   // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of 2.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // FIFO storage: data only, written on an accepted push.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= i_data_byte;
      end
   end

   // Frame byte is latched at pop so later pushes cannot disturb the frame in flight.
   always_ff @(posedge i_clk) begin
      if (pop) begin
         shift_reg <= fifo_mem[rd_ptr];
      end
   end

   // Frame sequencer with registered line/busy/done outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= IDLE;
         clk_ctr        <= '0;
         bit_ctr        <= '0;
         o_tx_data_line <= 1'b1;
         o_tx_busy      <= 1'b0;
         o_tx_done      <= 1'b0;
      end else begin
         o_tx_busy <= (state != IDLE);
         o_tx_done <= (state == CLEANUP);

         case (state)
            START_BIT: o_tx_data_line <= 1'b0;
            DATA_BITS: o_tx_data_line <= shift_reg[bit_ctr];
            default:   o_tx_data_line <= 1'b1;
         endcase

         case (state)
            IDLE: begin
               clk_ctr <= '0;
               bit_ctr <= '0;
               if (!fifo_empty) begin
                  state <= START_BIT;
               end
            end

            START_BIT: begin
               if (baud_last) begin
                  clk_ctr <= '0;
                  bit_ctr <= '0;
                  state   <= DATA_BITS;
               end else begin
                  clk_ctr <= clk_ctr + 1'b1;
               end
            end

            DATA_BITS: begin
               if (baud_last) begin
                  clk_ctr <= '0;
                  if (bit_ctr == BIT_LAST) begin
                     bit_ctr <= '0;
                     state   <= STOP_BIT;
                  end else begin
                     bit_ctr <= bit_ctr + 1'b1;
                  end
               end else begin
                  clk_ctr <= clk_ctr + 1'b1;
               end
            end

            STOP_BIT: begin
               if (baud_last) begin
                  clk_ctr <= '0;
                  state   <= CLEANUP;
               end else begin
                  clk_ctr <= clk_ctr + 1'b1;
               end
            end

            CLEANUP: begin
               clk_ctr <= '0;
               state   <= IDLE;
            end

            default: begin
               clk_ctr <= '0;
               bit_ctr <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_txr.sv
// tb_uart_txr: randomized self-checking bench for uart_txr.
// A behavioural receiver decodes the serial line by slot arithmetic (slot = clock / CPB)
// and compares each frame with a queue of bytes the handshake accepted.
module tb_uart_txr;

   localparam int CPB     = 8;
   localparam int CPB_DEF = 434;
   localparam int TIMEOUT = 20000;

   logic       clk = 1'b0;
   logic       rst;
   logic       v0, rdy0, tx0, busy0, done0;
   logic [7:0] d0;
   logic       v1, rdy1, tx1, busy1, done1;
   logic [7:0] d1;

   int cyc      = 0;
   int done_cnt = 0;
   int n_chk    = 0;
   int n_pass   = 0;

   logic [7:0] exp_q[$];
   int         acc_cyc[$];
   int         starts[$];

   uart_txr #(.CLKS_PER_BAUD_PERIOD(CPB), .FIFO_DEPTH(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_data_valid(v0), .i_data_byte(d0),
      .o_data_ready(rdy0), .o_tx_data_line(tx0), .o_tx_busy(busy0), .o_tx_done(done0)
   );

   uart_txr #(.CLKS_PER_BAUD_PERIOD(CPB_DEF), .FIFO_DEPTH(4)) dut_def (
      .i_clk(clk), .i_rst(rst), .i_data_valid(v1), .i_data_byte(d1),
      .o_data_ready(rdy1), .o_tx_data_line(tx1), .o_tx_busy(busy1), .o_tx_done(done1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (done0 === 1'b1) done_cnt = done_cnt + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: sim time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic tx_of(input bit sel);
      return sel ? tx1 : tx0;
   endfunction

   function automatic logic busy_of(input bit sel);
      return sel ? busy1 : busy0;
   endfunction

   function automatic logic done_of(input bit sel);
      return sel ? done1 : done0;
   endfunction

   // Behavioural receiver: waits for the start edge, then checks every clock of the
   // 10-slot frame (start 0, 8 data bits each constant for cpb clocks, stop 1), that
   // busy is high throughout and that done pulses exactly at clock 10*cpb.
   task automatic recv_frame(input int cpb, input bit sel, output logic [7:0] b,
                             output int s, output bit ok);
      int   t, err, slot;
      logic v, ref_v;
      b = '0; s = -1; ok = 1'b0; err = 0; ref_v = 1'b0; t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (tx_of(sel) !== 1'b0 && t < TIMEOUT);
      chk("frame_start", {31'b0, tx_of(sel)}, 32'd0);
      if (tx_of(sel) !== 1'b0) return;
      s  = cyc;
      ok = 1'b1;
      for (int k = 0; k <= 10 * cpb; k++) begin
         if (k > 0) @(negedge clk);
         v = tx_of(sel);
         if (k == 10 * cpb) begin
            if (v !== 1'b1 || done_of(sel) !== 1'b1 || busy_of(sel) !== 1'b1) err++;
         end else begin
            slot = k / cpb;
            if (k % cpb == 0) begin
               ref_v = v;
               if (slot >= 1 && slot <= 8) b = {v, b[7:1]};
            end else if (v !== ref_v) begin
               err++;
            end
            if (slot == 0 && v !== 1'b0) err++;
            if (slot == 9 && v !== 1'b1) err++;
            if (done_of(sel) !== 1'b0 || busy_of(sel) !== 1'b1) err++;
         end
      end
      chk("frame_shape", err, 32'd0);
   endtask

   // Offers each byte after a random idle gap (random junk on the data bus while idle)
   // and holds it until accepted; accepted bytes and their edge numbers are recorded.
   task automatic send_bytes(input logic [7:0] q[$], input int max_gap);
      int t, gap;
      foreach (q[i]) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (gap) begin
            v0 = 1'b0;
            d0 = 8'($urandom);
            @(negedge clk);
         end
         v0 = 1'b1;
         d0 = q[i];
         t  = 0;
         while (rdy0 !== 1'b1 && t < TIMEOUT) begin
            @(negedge clk);
            t++;
         end
         chk("send_rdy", {31'b0, rdy0}, 32'd1);
         if (rdy0 !== 1'b1) break;
         exp_q.push_back(q[i]);
         acc_cyc.push_back(cyc + 1);
         @(negedge clk);
      end
      v0 = 1'b0;
      d0 = 8'($urandom);
   endtask

   task automatic run_stream(input logic [7:0] q[$], input int max_gap, input string tag,
                             output int nrx);
      logic [7:0]  b;
      int          s, n;
      bit          ok;
      logic [31:0] e;
      exp_q.delete(); acc_cyc.delete(); starts.delete();
      nrx = 0;
      n   = q.size();
      fork
         send_bytes(q, max_gap);
         begin
            for (int i = 0; i < n; i++) begin
               recv_frame(CPB, 1'b0, b, s, ok);
               if (!ok) break;
               starts.push_back(s);
               nrx++;
               e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h100;
               chk({tag, "_byte"}, 32'(b), e);
            end
         end
      join
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] b;
      int         nrx, dn, s, acc, lows, busies, s0, t;
      bit         ok;

      rst = 1'b1; v0 = 1'b0; d0 = '0; v1 = 1'b0; d1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_line", {31'b0, tx0}, 32'd1);
      chk("rst_busy", {31'b0, busy0}, 32'd0);
      chk("rst_done", {31'b0, done0}, 32'd0);
      chk("rst_rdy", {31'b0, rdy0}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst", {31'b0, rdy0}, 32'd1);
      repeat (4) @(negedge clk);

      // single byte: latency and done position
      dn = done_cnt;
      q = {8'hA5};
      run_stream(q, 0, "t1", nrx);
      chk("t1_frames", nrx, 32'd1);
      if (nrx == 1) chk("t1_latency", starts[0] - acc_cyc[0], 32'd2);
      repeat (3) @(negedge clk);
      chk("t1_done_cnt", done_cnt - dn, 32'd1);
      repeat (4) @(negedge clk);

      // back-to-back frames: 2-clock gap after each stop bit
      dn = done_cnt;
      q = {8'h00, 8'hFF, 8'h55};
      run_stream(q, 0, "t2", nrx);
      chk("t2_frames", nrx, 32'd3);
      if (nrx == 3) begin
         chk("t2_gap0", starts[1] - starts[0], 32'(10 * CPB + 2));
         chk("t2_gap1", starts[2] - starts[1], 32'(10 * CPB + 2));
      end
      repeat (3) @(negedge clk);
      chk("t2_done_cnt", done_cnt - dn, 32'd3);
      repeat (4) @(negedge clk);

      // full FIFO: 5 taken back-to-back, 6th held until the first queued byte leaves
      q = {8'h3A, 8'hC4, 8'h5B, 8'h96, 8'h0F, 8'hE1};
      run_stream(q, 0, "t3", nrx);
      chk("t3_frames", nrx, 32'd6);
      if (acc_cyc.size() == 6) begin
         chk("t3_acc_burst", acc_cyc[4] - acc_cyc[0], 32'd4);
         chk("t3_acc_held", acc_cyc[5] - acc_cyc[0], 32'(10 * CPB + 4));
      end
      if (nrx == 6)
         for (int i = 1; i < 6; i++) chk("t3_gap", starts[i] - starts[i-1], 32'(10 * CPB + 2));
      repeat (4) @(negedge clk);

      // reset during data bit 3 of 0x3C with two bytes queued
      exp_q.delete(); acc_cyc.delete();
      q = {8'h3C, 8'h11, 8'h22};
      send_bytes(q, 0);
      s0 = (acc_cyc.size() > 0) ? acc_cyc[0] + 2 : cyc;
      t = 0;
      while (cyc < s0 + 35 && t < TIMEOUT) begin
         @(negedge clk);
         t++;
      end
      chk("t4_busy_pre", {31'b0, busy0}, 32'd1);
      chk("t4_bit3", {31'b0, tx0}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t4_line", {31'b0, tx0}, 32'd1);
      chk("t4_busy", {31'b0, busy0}, 32'd0);
      chk("t4_rdy_in_rst", {31'b0, rdy0}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("t4_rdy", {31'b0, rdy0}, 32'd1);
      dn = done_cnt; lows = 0; busies = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx0 !== 1'b1) lows++;
         if (busy0 !== 1'b0) busies++;
      end
      chk("t4_no_frame", lows, 32'd0);
      chk("t4_no_busy", busies, 32'd0);
      chk("t4_no_done", done_cnt - dn, 32'd0);
      exp_q.delete();

      // all byte values with random idle gaps
      dn = done_cnt;
      q.delete();
      for (int i = 0; i < 256; i++) q.push_back(8'(i));
      run_stream(q, 3, "t5", nrx);
      chk("t5_frames", nrx, 32'd256);
      repeat (3) @(negedge clk);
      chk("t5_done_cnt", done_cnt - dn, 32'd256);
      repeat (4) @(negedge clk);

      // random bytes, wider random gaps (FSM alternately idle and saturated)
      q.delete();
      for (int i = 0; i < 48; i++) q.push_back(8'($urandom));
      run_stream(q, 12, "t7", nrx);
      chk("t7_frames", nrx, 32'd48);
      repeat (4) @(negedge clk);

      // default baud period instance
      chk("t6_rdy", {31'b0, rdy1}, 32'd1);
      v1 = 1'b1; d1 = 8'h81;
      @(negedge clk);
      acc = cyc;
      v1 = 1'b0; d1 = 8'h7E;
      recv_frame(CPB_DEF, 1'b1, b, s, ok);
      if (ok) begin
         chk("t6_latency", s - acc, 32'd2);
         chk("t6_byte", 32'(b), 32'h81);
      end
      @(negedge clk);
      chk("t6_idle_line", {31'b0, tx1}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
